// File: rtl/vc_pop_arbiter.sv
// rtl/vc_pop_arbiter.sv - VC FIFO drain arbiter routing words to class destinations
// Define VC_ARB_STRICT_PRIO_EN for fixed priority (source 0 highest) instead of round-robin.
module vc_pop_arbiter #(
  parameter int DATA_W = 10,
  parameter int N_SRC  = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [3:0]                state,
  input  logic [N_SRC-1:0]          fifo_empty,
  input  logic [N_SRC*DATA_W-1:0]   fifo_data,
  input  logic [3:0]                dst_almost_full,
  output logic [N_SRC-1:0]          pop,
  output logic [3:0]                push,
  output logic [DATA_W-1:0]         data_out,
  output logic                      idle
);

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  logic [1:0]        sel_q, sel_d;
  logic              v1_q, v1_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        push_q, push_d;
  logic [1:0]        gnt_idx;
  logic              grant;
  logic              arb_en;
  logic [DATA_W-1:0] rd_word;

  assign arb_en = (state == ST_IDLE) || (state == ST_ACTIVE);
  // Destination is unknown until the word is read, so any almost_full stalls grants.
  assign grant  = reset_L && arb_en && (dst_almost_full == 4'b0000) && !(&fifo_empty);

`ifdef VC_ARB_STRICT_PRIO_EN
  always_comb begin
    gnt_idx = 2'd0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (!fifo_empty[k]) gnt_idx = 2'(k);
    end
  end
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    logic [1:0] cand;
    logic       found;
    gnt_idx = 2'd0;
    found   = 1'b0;
    cand    = 2'd0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!found && !fifo_empty[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state == ST_RESET)
      rr_ptr_d = 2'd0;
    else if (grant)
      rr_ptr_d = gnt_idx + 2'd1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      rr_ptr_q <= 2'd0;
    else
      rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign pop     = grant ? (N_SRC'(1) << gnt_idx) : '0;
  assign rd_word = fifo_data[int'(sel_q)*DATA_W +: DATA_W];

  // In-flight words always drain; only the RESET state flushes the pipeline.
  always_comb begin
    sel_d  = grant ? gnt_idx : sel_q;
    v1_d   = grant;
    data_d = v1_q ? rd_word : data_q;
    push_d = v1_q ? (4'b0001 << rd_word[DATA_W-1 -: 2]) : 4'b0000;
    if (state == ST_RESET) begin
      sel_d  = 2'd0;
      v1_d   = 1'b0;
      data_d = '0;
      push_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_q  <= 2'd0;
      v1_q   <= 1'b0;
      data_q <= '0;
      push_q <= 4'b0000;
    end else begin
      sel_q  <= sel_d;
      v1_q   <= v1_d;
      data_q <= data_d;
      push_q <= push_d;
    end
  end

  assign push     = push_q;
  assign data_out = data_q;
  assign idle     = (&fifo_empty) & ~v1_q & ~(|push_q);

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb/tb_vc_pop_arbiter.sv - scoreboard bench for vc_pop_arbiter against a queue-based model
module tb_vc_pop_arbiter;

  localparam logic [3:0] S_RESET = 4'b0001, S_INIT = 4'b0010, S_IDLE = 4'b0100, S_ACTIVE = 4'b1000;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [3:0]  state;
  logic [3:0]  fifo_empty;
  logic [39:0] fifo_data;
  logic [3:0]  dst_almost_full;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [9:0]  data_out;
  logic        idle;

  vc_pop_arbiter dut (
    .clk(clk), .reset_L(reset_L), .state(state), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .dst_almost_full(dst_almost_full),
    .pop(pop), .push(push), .data_out(data_out), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [9:0] w; } exp_t;

  logic [9:0] srcq [4][$];
  exp_t       exp_q[$];
  int         cyc = 0;
  int         rr = 0;
  int         last_g = -1;
  int         n_pass = 0;
  int         n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int model_grant();
    if (!reset_L) return -1;
    if (!(state == S_IDLE || state == S_ACTIVE)) return -1;
    if (dst_almost_full != 4'b0000) return -1;
`ifdef VC_ARB_STRICT_PRIO_EN
    for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) return i;
`else
    for (int k = 0; k < 4; k++) if (srcq[(rr + k) % 4].size() > 0) return (rr + k) % 4;
`endif
    return -1;
  endfunction

  task automatic drop_from(input int lim);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].due >= lim) exp_q.delete(i);
  endtask

  function automatic bit word_in_flight(input int upto);
    foreach (exp_q[i]) if (exp_q[i].due <= upto) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic [3:0] st, input logic [3:0] af, input bit rst_n);
    int         g;
    logic [3:0] exp_pop;
    @(posedge clk); #1;
    if (last_g >= 0) fifo_data[last_g*10 +: 10] = srcq[last_g].pop_front();
    if (!rst_n) begin
      reset_L = 1'b0;
      drop_from(cyc);
      rr = 0;
    end else begin
      reset_L = 1'b1;
    end
    state = st;
    dst_almost_full = af;
    for (int i = 0; i < 4; i++) fifo_empty[i] = (srcq[i].size() == 0);
    @(negedge clk);
    chk("idle", idle, (&fifo_empty) && !word_in_flight(cyc + 1));
    g = model_grant();
    exp_pop = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("pop", pop, exp_pop);
    if (!reset_L) chk("data_out_reset", data_out, 0);
    if (reset_L && st == S_RESET) begin
      drop_from(cyc + 1);
      rr = 0;
    end
    if (g >= 0) begin
      exp_q.push_back('{due: cyc + 2, w: srcq[g][0]});
      rr = (g + 1) % 4;
    end
    last_g = g;
  endtask

  task automatic fill(input int src, input int n);
    for (int i = 0; i < n; i++) srcq[src].push_back(10'($urandom));
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] exp_push;
    forever begin
      @(negedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        exp_push = 4'b0001 << e.w[9:8];
        chk("push", push, exp_push);
        chk("data_out", data_out, e.w);
      end else begin
        chk("push_none", push, 0);
      end
    end
  end

  initial begin : driver
    reset_L = 1'b0; state = S_RESET; fifo_empty = 4'hF; fifo_data = '0; dst_almost_full = 4'h0;
    repeat (2) step(S_RESET, 4'h0, 1'b0);
    step(S_RESET, 4'h0, 1'b1);

    // Round-robin over four loaded sources; source 0 leads with class-2 word 0x2A5.
    srcq[0].push_back(10'h2A5);
    fill(0, 2); fill(1, 2); fill(2, 2); fill(3, 2);
    repeat (6) step(S_ACTIVE, 4'h0, 1'b1);

    // Stall on almost_full after two grants, then resume.
    fill(0, 2); fill(1, 2); fill(2, 2); fill(3, 2);
    repeat (2) step(S_ACTIVE, 4'h0, 1'b1);
    repeat (3) step(S_ACTIVE, 4'b1000, 1'b1);
    repeat (8) step(S_ACTIVE, 4'h0, 1'b1);
    repeat (6) step(S_ACTIVE, 4'h0, 1'b1);

    // Empty skip: only source 2 holds data, pointer lands on 3 and stays there.
    fill(2, 1);
    repeat (3) step(S_ACTIVE, 4'h0, 1'b1);
    fill(2, 1);
    repeat (4) step(S_ACTIVE, 4'h0, 1'b1);

    // INIT gating mid-stream, then a synchronous RESET state clear.
    fill(0, 1); fill(1, 1); fill(2, 1); fill(3, 1);
    repeat (2) step(S_ACTIVE, 4'h0, 1'b1);
    repeat (6) step(S_INIT, 4'h0, 1'b1);
    repeat (4) step(S_ACTIVE, 4'h0, 1'b1);
    fill(0, 3); fill(1, 3);
    repeat (2) step(S_ACTIVE, 4'h0, 1'b1);
    repeat (2) step(S_RESET, 4'h0, 1'b1);
    repeat (8) step(S_ACTIVE, 4'h0, 1'b1);

    // Async reset with a word in flight.
    fill(1, 1);
    step(S_ACTIVE, 4'h0, 1'b1);
    step(S_ACTIVE, 4'h0, 1'b0);
    repeat (4) step(S_ACTIVE, 4'h0, 1'b1);

    // Sources 0 and 3 both loaded (strict build: source 0 drains first).
    fill(0, 3); fill(3, 3);
    repeat (10) step(S_ACTIVE, 4'h0, 1'b1);

    // Randomized traffic, stalls, state changes and resets.
    for (int c = 0; c < 1500; c++) begin
      int          r;
      logic [3:0]  st, af;
      bit          rn;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 99) < 30 && srcq[i].size() < 6) fill(i, 1);
      r  = $urandom_range(0, 99);
      st = (r < 3) ? S_RESET : (r < 10) ? S_INIT : (r < 25) ? S_IDLE : S_ACTIVE;
      af = ($urandom_range(0, 99) < 20) ? 4'($urandom_range(1, 15)) : 4'h0;
      rn = ($urandom_range(0, 99) >= 1);
      step(st, af, rn);
    end

    repeat (40) step(S_ACTIVE, 4'h0, 1'b1);
    repeat (4) step(S_INIT, 4'h0, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
